fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//   Instruction-fetch stage directly upstream of the decoder. Holds the
//   program counter, addresses the instruction ROM, and passes the fetched
//   9-bit instruction to the decoder.
//   Consumes the decoder's jump/imm/done outputs and the resolved BEQ
//   result to compute the next PC.
//   Sequences a program run: start -> run -> halt/ack, and counts run cycles.
//
// PARAMETERS
//   PC_WIDTH     10  width of program counter / instruction ROM address
//   INSTR_WIDTH   9  instruction width (matches decoder instr_width)
//   OFF_WIDTH     8  width of signed jump offset (matches decoder reg_width)
//   CNT_WIDTH    16  width of run-cycle counter
//
// PORTS
//   clk           in   1            system clock, rising edge
//   reset         in   1            asynchronous, active-high reset
//   start         in   1            begin program at start_addr (sampled in IDLE/HALTED)
//   start_addr    in   PC_WIDTH     first PC of program
//   instr_in      in   INSTR_WIDTH  instruction ROM data; combinational read of pc
//   jump          in   1            decoder jump (JR) for current instruction
//   offset        in   OFF_WIDTH    decoder imm, two's-complement PC offset for JR
//   branch_taken  in   1            BEQ compare true for current instruction
//   halt          in   1            decoder done for current instruction
//   pc            out  PC_WIDTH     current PC, drives instruction ROM address
//   instruction   out  INSTR_WIDTH  to decoder; = instr_in (combinational)
//   running       out  1            1 while state==RUN; downstream gates writes
//   ack           out  1            one-cycle pulse: program reached halt
//   cycle_count   out  CNT_WIDTH    RUN cycles of last/current program
//
// BEHAVIOUR
//   Reset (async, any time incl. mid-run): state=IDLE, pc=0, ack=0,
//     cycle_count=0. running=0 from the reset edge.
//   States: IDLE, RUN, HALTED. running = (state==RUN), decoded from state reg.
//   IDLE/HALTED: pc holds. start=1 -> next cycle state=RUN, pc=start_addr,
//     cycle_count=0, ack=0.
//   RUN, one instruction per cycle; next-PC priority at each rising edge:
//     1. halt=1        -> state=HALTED, pc holds, ack=1 next cycle
//     2. jump=1        -> pc = pc + sign_extend(offset)
//     3. branch_taken  -> pc = pc + 2 (skip next instruction)
//     4. otherwise     -> pc = pc + 1
//   PC arithmetic is modulo 2^PC_WIDTH; wrap at both ends, no error flag.
//   offset is sign-extended from OFF_WIDTH to PC_WIDTH before the add.
//   start is ignored while in RUN.
//   jump/branch_taken/halt are ignored outside RUN.
//   cycle_count: +1 every RUN cycle incl. the halting cycle; saturates at
//     all-ones; holds in HALTED; cleared on start.
//   ack: registered; high exactly one cycle (first HALTED cycle), else 0.
//   start on the same edge ack is high: the restart is taken.
//   instruction is not registered; fetch-to-decode latency is 0 cycles.
//
// TESTING
//   1 reset, start=1 start_addr=0x010, 4 plain instrs -> pc 0x010,011,012,013,014
//   2 RUN at pc=0x020, jump=1 offset=0xFD -> pc=0x01D; offset=0x05 -> pc=0x025
//   3 pc=0x030, branch_taken=1 -> pc=0x032; jump=1 and branch_taken=1 at
//     pc=0x030 offset=0x04 -> pc=0x034
//   4 program of 7 instrs ending with halt -> ack one cycle, cycle_count=7,
//     pc frozen, running=0; restart via start -> cycle_count back to 0
//   5 pc=0x3FF plain -> pc=0x000; pc=0x001 jump offset=0xFE -> pc=0x3FF
//   6 reset asserted mid-run between edges -> outputs zero immediately,
//     IDLE; later start ignores stale halt/jump inputs while IDLE

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: program-run handshake, instruction ROM access and
// decoder feedback grouped into one bundle.
//   master : environment side (drives start/ROM data/decoder results)
//   slave  : fetch_unit side (drives pc/instruction/status)
// Signals:
//   start, start_addr         begin a program run at start_addr
//   instr_in                  instruction ROM data for the current pc
//   jump, offset              decoder JR request and signed PC offset
//   branch_taken              resolved BEQ compare for the current instruction
//   halt                      decoder done for the current instruction
//   pc                        current program counter / ROM address
//   instruction               instruction forwarded to the decoder
//   running                   high while a program is executing
//   ack                       one-cycle pulse when a program halts
//   cycle_count               RUN cycles of the last/current program
interface fetch_if #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9,
    parameter int OFF_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16
);
    logic                   start;
    logic [PC_WIDTH-1:0]    start_addr;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic                   jump;
    logic [OFF_WIDTH-1:0]   offset;
    logic                   branch_taken;
    logic                   halt;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   running;
    logic                   ack;
    logic [CNT_WIDTH-1:0]   cycle_count;

    modport master (
        output start, start_addr, instr_in, jump, offset, branch_taken, halt,
        input  pc, instruction, running, ack, cycle_count
    );

    modport slave (
        input  start, start_addr, instr_in, jump, offset, branch_taken, halt,
        output pc, instruction, running, ack, cycle_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the program counter, addresses the
// instruction ROM, forwards the fetched instruction to the decoder with no
// added latency, and computes the next PC from the decoder's halt/jump
// outputs and the resolved branch result. Sequences IDLE -> RUN -> HALTED
// and counts the RUN cycles of each program.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    fetch_if slave modport (see fetch_if for signal list)
module fetch_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9,
    parameter int OFF_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16
) (
    input logic    clk,
    input logic    reset,
    fetch_if.slave bus
);
    localparam int EXT_WIDTH = PC_WIDTH - OFF_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic [PC_WIDTH-1:0]    offset_ext;

    // Two's-complement offset widened to PC width before the modulo add.
    assign offset_ext = {{EXT_WIDTH{bus.offset[OFF_WIDTH-1]}}, bus.offset};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            RUN: begin
                // The halting cycle is itself a RUN cycle and is counted.
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                if (bus.halt) begin
                    state_d = HALTED;
                    ack_d   = 1'b1;
                end else if (bus.jump) begin
                    pc_d = pc_q + offset_ext;
                end else if (bus.branch_taken) begin
                    pc_d = pc_q + PC_WIDTH'(2);
                end else begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
            end
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.instruction = bus.instr_in;
    assign bus.running     = (state_q == RUN);
    assign bus.ack         = ack_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: next-PC priority, wrap-around, halt/ack
// sequencing, cycle counting, restart and asynchronous reset.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fetch_if #(
        .PC_WIDTH    (10),
        .INSTR_WIDTH (9),
        .OFF_WIDTH   (8),
        .CNT_WIDTH   (16)
    ) bus ();

    fetch_unit #(
        .PC_WIDTH    (10),
        .INSTR_WIDTH (9),
        .OFF_WIDTH   (8),
        .CNT_WIDTH   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [9:0] addr);
        bus.start      = 1'b1;
        bus.start_addr = addr;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic stop();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
    endtask

    initial begin
        tests            = 0;
        fails            = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.start_addr   = '0;
        bus.instr_in     = 9'h1A5;
        bus.jump         = 1'b0;
        bus.offset       = '0;
        bus.branch_taken = 1'b0;
        bus.halt         = 1'b0;

        #12;
        check("rst_pc",      32'(bus.pc), 32'h0);
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_ack",     32'(bus.ack), 32'h0);
        check("rst_cnt",     32'(bus.cycle_count), 32'h0);
        check("instr_pass",  32'(bus.instruction), 32'h1A5);
        reset = 1'b0;

        // Idle: pc holds without start.
        tick();
        check("idle_pc", 32'(bus.pc), 32'h0);

        // 1: sequential fetch
        go(10'h010);
        check("t1_pc0",  32'(bus.pc), 32'h010);
        check("t1_run",  32'(bus.running), 32'h1);
        check("t1_cnt0", 32'(bus.cycle_count), 32'h0);
        tick(); check("t1_pc1", 32'(bus.pc), 32'h011);
        tick(); check("t1_pc2", 32'(bus.pc), 32'h012);
        tick(); check("t1_pc3", 32'(bus.pc), 32'h013);
        bus.instr_in = 9'h07E;
        #1;
        check("instr_pass2", 32'(bus.instruction), 32'h07E);
        // start is ignored while running
        bus.start = 1'b1; bus.start_addr = 10'h300;
        tick(); check("t1_pc4", 32'(bus.pc), 32'h014);
        bus.start = 1'b0;
        check("t1_cnt4", 32'(bus.cycle_count), 32'h4);
        stop();
        check("t1_halt_ack", 32'(bus.ack), 32'h1);
        check("t1_halt_pc",  32'(bus.pc), 32'h014);
        check("t1_halt_cnt", 32'(bus.cycle_count), 32'h5);
        check("t1_halt_run", 32'(bus.running), 32'h0);
        tick();
        check("t1_ack_drop", 32'(bus.ack), 32'h0);

        // 2: jumps with negative and positive offsets
        go(10'h020);
        bus.jump = 1'b1; bus.offset = 8'hFD;
        tick(); check("t2_jneg", 32'(bus.pc), 32'h01D);
        bus.jump = 1'b0;
        stop();
        go(10'h020);
        bus.jump = 1'b1; bus.offset = 8'h05;
        tick(); check("t2_jpos", 32'(bus.pc), 32'h025);
        bus.jump = 1'b0;
        stop();

        // 3: branch skip, and jump over branch priority
        go(10'h030);
        bus.branch_taken = 1'b1;
        tick(); check("t3_br", 32'(bus.pc), 32'h032);
        bus.branch_taken = 1'b0;
        stop();
        go(10'h030);
        bus.jump = 1'b1; bus.branch_taken = 1'b1; bus.offset = 8'h04;
        tick(); check("t3_jbr", 32'(bus.pc), 32'h034);
        // halt beats jump
        bus.halt = 1'b1;
        tick();
        check("t3_hj_pc",  32'(bus.pc), 32'h034);
        check("t3_hj_ack", 32'(bus.ack), 32'h1);
        bus.halt = 1'b0;
        // decoder inputs ignored in HALTED
        tick();
        check("t3_hlt_pc", 32'(bus.pc), 32'h034);
        bus.jump = 1'b0; bus.branch_taken = 1'b0; bus.offset = '0;

        // 4: 7-instruction program, halt on the 7th
        go(10'h100);
        for (int unsigned i = 0; i < 6; i++) tick();
        check("t4_pc6", 32'(bus.pc), 32'h106);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("t4_ack", 32'(bus.ack), 32'h1);
        check("t4_cnt", 32'(bus.cycle_count), 32'h7);
        check("t4_pc",  32'(bus.pc), 32'h106);
        check("t4_run", 32'(bus.running), 32'h0);
        tick();
        check("t4_ack_one", 32'(bus.ack), 32'h0);
        check("t4_cnt_hold", 32'(bus.cycle_count), 32'h7);
        check("t4_pc_hold", 32'(bus.pc), 32'h106);
        go(10'h200);
        check("t4_rs_cnt", 32'(bus.cycle_count), 32'h0);
        check("t4_rs_run", 32'(bus.running), 32'h1);
        check("t4_rs_pc",  32'(bus.pc), 32'h200);
        // restart on the same edge ack is high
        tick(); tick();
        stop();
        check("t4_ack2", 32'(bus.ack), 32'h1);
        check("t4_cnt3", 32'(bus.cycle_count), 32'h3);
        go(10'h050);
        check("t4_ra_pc",  32'(bus.pc), 32'h050);
        check("t4_ra_run", 32'(bus.running), 32'h1);
        check("t4_ra_ack", 32'(bus.ack), 32'h0);
        check("t4_ra_cnt", 32'(bus.cycle_count), 32'h0);
        stop();

        // 5: wrap at both ends
        go(10'h3FF);
        tick(); check("t5_wrap_up", 32'(bus.pc), 32'h000);
        stop();
        go(10'h001);
        bus.jump = 1'b1; bus.offset = 8'hFE;
        tick(); check("t5_wrap_dn", 32'(bus.pc), 32'h3FF);
        bus.jump = 1'b0;
        bus.branch_taken = 1'b1;
        tick(); check("t5_br_wrap", 32'(bus.pc), 32'h001);
        bus.branch_taken = 1'b0;

        // 6: asynchronous reset between edges
        tick();
        check("t6_pre", 32'(bus.pc), 32'h002);
        #2 reset = 1'b1;
        #1;
        check("t6_pc",      32'(bus.pc), 32'h0);
        check("t6_running", 32'(bus.running), 32'h0);
        check("t6_ack",     32'(bus.ack), 32'h0);
        check("t6_cnt",     32'(bus.cycle_count), 32'h0);
        reset = 1'b0;
        bus.halt = 1'b1; bus.jump = 1'b1; bus.offset = 8'h05; bus.branch_taken = 1'b1;
        tick();
        check("t6_idle_pc",  32'(bus.pc), 32'h0);
        check("t6_idle_run", 32'(bus.running), 32'h0);
        check("t6_idle_ack", 32'(bus.ack), 32'h0);
        bus.start = 1'b1; bus.start_addr = 10'h0AA;
        tick();
        bus.start = 1'b0;
        check("t6_st_pc",  32'(bus.pc), 32'h0AA);
        check("t6_st_run", 32'(bus.running), 32'h1);
        check("t6_st_ack", 32'(bus.ack), 32'h0);
        tick();
        check("t6_halt_ack", 32'(bus.ack), 32'h1);
        check("t6_halt_cnt", 32'(bus.cycle_count), 32'h1);
        bus.halt = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Bound on total runtime in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
